// File: rtl/fxp_mac_dot.sv
// Saturating fixed-point dot-product engine: four-stage multiply/round/accumulate
// pipeline fed over valid/ready, sequenced by a start/done FSM.
module fxp_mac_dot #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int LEN  = 10,
  localparam int CW  = ($clog2(LEN + 1) < 1) ? 1 : $clog2(LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_acc_mode,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_result,
  output logic          o_sat_flag,
  output logic          o_busy,
  output logic [CW-1:0] o_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Symmetric clamp limits; the most negative code is never produced.
  localparam logic signed [DW-1:0]   MAX_Q = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   MIN_Q = -MAX_Q;
  localparam logic signed [2*DW:0]   MAX_W = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0]   MIN_W = -MAX_W;
  localparam logic signed [2*DW:0]   RND_W = (2*DW+1)'(1) << (FRAC - 1);
  localparam logic signed [DW:0]     MAX_S = {1'b0, MAX_Q};
  localparam logic signed [DW:0]     MIN_S = {1'b1, MIN_Q};

  state_t r_state;
  state_t w_state_next;
  logic [1:0]    r_drain;
  logic [CW-1:0] r_count;

  logic                    r_s1_vld;
  logic signed [DW-1:0]    r_s1_a;
  logic signed [DW-1:0]    r_s1_b;
  logic                    r_s2_vld;
  logic signed [2*DW-1:0]  r_s2_prod;
  logic                    r_s3_vld;
  logic signed [DW-1:0]    r_s3_q;
  logic                    r_s3_sat;
  logic signed [DW-1:0]    r_acc;
  logic                    r_sat;

  logic                    w_accept;
  logic                    w_start_go;
  logic signed [2*DW:0]    w_rnd;
  logic signed [2*DW:0]    w_shift;
  logic signed [DW-1:0]    w_prod_q;
  logic                    w_prod_sat;
  logic signed [DW:0]      w_sum;
  logic signed [DW-1:0]    w_sum_q;
  logic                    w_sum_sat;

  assign w_accept   = i_in_valid & o_in_ready;
  assign w_start_go = (r_state == S_IDLE) & i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        o_in_ready = 1'b1;
        if (i_in_valid && (r_count == CW'(LEN - 1))) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Three edges after the last accept the accumulator holds the final sum.
        if (r_drain == 2'd2) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drain <= 2'd0;
      r_count <= '0;
    end else begin
      if (r_state == S_DRAIN) r_drain <= r_drain + 2'd1;
      else                    r_drain <= 2'd0;
      if (w_start_go)    r_count <= '0;
      else if (w_accept) r_count <= r_count + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_prod <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_q    <= '0;
      r_s3_sat  <= 1'b0;
    end else begin
      r_s1_vld  <= w_accept;
      if (w_accept) begin
        r_s1_a <= i_a;
        r_s1_b <= i_b;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_prod <= r_s1_a * r_s1_b;
      r_s3_vld  <= r_s2_vld;
      r_s3_q    <= w_prod_q;
      r_s3_sat  <= w_prod_sat;
    end
  end

  // Round half up, then clamp the rescaled product to the symmetric range.
  assign w_rnd   = {r_s2_prod[2*DW-1], r_s2_prod} + RND_W;
  assign w_shift = w_rnd >>> FRAC;

  always_comb begin
    w_prod_q   = w_shift[DW-1:0];
    w_prod_sat = 1'b0;
    if (w_shift > MAX_W) begin
      w_prod_q   = MAX_Q;
      w_prod_sat = 1'b1;
    end else if (w_shift < MIN_W) begin
      w_prod_q   = MIN_Q;
      w_prod_sat = 1'b1;
    end
  end

  assign w_sum = {r_acc[DW-1], r_acc} + {r_s3_q[DW-1], r_s3_q};

  always_comb begin
    w_sum_q   = w_sum[DW-1:0];
    w_sum_sat = 1'b0;
    if (w_sum > MAX_S) begin
      w_sum_q   = MAX_Q;
      w_sum_sat = 1'b1;
    end else if (w_sum < MIN_S) begin
      w_sum_q   = MIN_Q;
      w_sum_sat = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_start_go) begin
      if (!i_acc_mode) r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_s3_vld) begin
      r_acc <= w_sum_q;
      if (r_s3_sat || w_sum_sat) r_sat <= 1'b1;
    end
  end

  assign o_result   = r_acc;
  assign o_sat_flag = r_sat;
  assign o_count    = r_count;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_fxp_mac_dot.sv
// Directed bench for fxp_mac_dot: hand-computed dot products, timing and flow control.
module tb_fxp_mac_dot;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        acc_mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        sat_flag;
  logic        busy;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  fxp_mac_dot #(.DW(16), .FRAC(8), .LEN(10)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_acc_mode  (acc_mode),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_sat_flag  (sat_flag),
    .o_busy      (busy),
    .o_count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete run: start, 10 beats (optionally gapped), wait for DONE, hold, handshake.
  task automatic run(input string name, input logic mode, input logic [15:0] va,
                     input logic [15:0] vb, input bit gap, input int hold, input bit poke,
                     input logic [15:0] exp_res, input logic exp_sat);
    int beats;
    int cyc;
    int k;
    @(negedge clk);
    start = 1'b1;
    acc_mode = mode;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".rdy_after_start"}, in_ready, 1);
    chk({name, ".busy"}, busy, 1);
    chk({name, ".sat_cleared"}, sat_flag, 0);
    chk({name, ".count0"}, count, 0);
    beats = 0;
    cyc = 0;
    while (beats < 10 && cyc < 100) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      a = va;
      b = vb;
      start = poke && (cyc == 2);
      if (in_valid && in_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({name, ".beats"}, beats, 10);
    chk({name, ".drain_rdy"}, in_ready, 0);
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, ".latency"}, k, 4);
    chk({name, ".count"}, count, 10);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = poke && (h == 1);
      chk({name, ".hold_res"}, result, exp_res);
      chk({name, ".hold_vld"}, out_valid, 1);
      chk({name, ".done_rdy"}, in_ready, 0);
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, ".result"}, result, exp_res);
    chk({name, ".sat"}, sat_flag, exp_sat);
    chk({name, ".out_valid"}, out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".idle_busy"}, busy, 0);
    chk({name, ".idle_vld"}, out_valid, 0);
    chk({name, ".kept_res"}, result, exp_res);
    $display("run %s: result=0x%04h sat=%0d", name, result, sat_flag);
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    start = 1'b0;
    acc_mode = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.in_ready", in_ready, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.result", result, 0);
    chk("reset.sat", sat_flag, 0);
    chk("reset.busy", busy, 0);
    chk("reset.count", count, 0);

    run("basic",   1'b0, 16'h0100, 16'h0100, 1'b0, 0, 1'b0, 16'h0A00, 1'b0);
    run("rnd_pos", 1'b0, 16'h0180, 16'h0001, 1'b0, 0, 1'b0, 16'h0014, 1'b0);
    run("rnd_neg", 1'b0, 16'hFE80, 16'h0001, 1'b0, 0, 1'b0, 16'hFFF6, 1'b0);
    run("sat_pos", 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 0, 1'b0, 16'h7FFF, 1'b1);
    run("sat_neg", 1'b0, 16'h7FFF, 16'h8001, 1'b0, 0, 1'b0, 16'h8001, 1'b1);
    run("flow",    1'b0, 16'h0100, 16'h0100, 1'b1, 5, 1'b1, 16'h0A00, 1'b0);
    run("cont",    1'b1, 16'h0100, 16'h0100, 1'b0, 0, 1'b0, 16'h1400, 1'b0);

    // Abort a run after four accepted beats.
    @(negedge clk);
    start = 1'b1;
    acc_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      in_valid = 1'b1;
      a = 16'h0100;
      b = 16'h0100;
      if (in_ready) beats++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.sat", sat_flag, 0);
    chk("rst.busy", busy, 0);
    chk("rst.count", count, 0);
    $display("mid-run reset after %0d beats", beats);

    run("after_rst", 1'b0, 16'h0100, 16'h0100, 1'b0, 0, 1'b0, 16'h0A00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
